// File: rtl/dich_seq_if.sv
// Handshake and serial-output bundle between the frame sequencer and its
// controller. The controller drives the request side (master) and the
// sequencer drives the serial side (slave).
interface dich_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] pat;
    logic             rpt;
    logic             stop;
    logic             DIN;
    logic             sh_en;
    logic             busy;
    logic             done;

    modport master (
        output start, pat, rpt, stop,
        input  DIN, sh_en, busy, done
    );

    modport slave (
        input  start, pat, rpt, stop,
        output DIN, sh_en, busy, done
    );
endinterface

// File: rtl/dich_seq.sv
// Frame sequencer for the 8-bit serial shift register. It accepts a parallel
// pattern on start, sends it MSB-first on DIN with an sh_en qualifier, and
// pulses done once after every frame. In repeat mode it re-latches pat after
// an idle gap of GAP cycles, or back-to-back when GAP is 0.
module dich_seq #(
    parameter int WIDTH = 8,
    parameter int GAP   = 4
) (
    input  logic       clk,
    input  logic       rs,
    dich_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_r, state_s;
    // Shadow holds the bits still to be sent; the bit on DIN has already left it.
    logic [WIDTH-1:0] shadow_r, shadow_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [GW-1:0]    gap_cnt_r, gap_cnt_s;
    logic             stop_pend_r, stop_pend_s;
    logic             din_r, din_s;
    logic             sh_en_r, sh_en_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             stop_any_s;
    logic             load_s;
    logic             idle_s;

    // Next-state and next-output decode; a frame load and a return to idle
    // are flagged first and applied once after the state case.
    always_comb begin
        state_s     = state_r;
        shadow_s    = shadow_r;
        cnt_s       = cnt_r;
        gap_cnt_s   = gap_cnt_r;
        stop_pend_s = stop_pend_r | (busy_r & bus.stop);
        din_s       = 1'b0;
        sh_en_s     = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        load_s      = 1'b0;
        idle_s      = 1'b0;
        // A stop arriving on the deciding cycle counts as well as a pending one.
        stop_any_s  = stop_pend_r | bus.stop;

        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    load_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    done_s = 1'b1;
                    cnt_s  = {CW{1'b0}};
                    if (bus.rpt && !stop_any_s) begin
                        if (GAP > 0) begin
                            // The done cycle is the first of the gap cycles.
                            state_s   = S_GAP;
                            gap_cnt_s = {GW{1'b0}};
                            busy_s    = 1'b1;
                        end else begin
                            load_s = 1'b1;
                        end
                    end else begin
                        idle_s = 1'b1;
                    end
                end else begin
                    cnt_s    = cnt_r + 1'b1;
                    din_s    = shadow_r[WIDTH-1];
                    shadow_s = {shadow_r[WIDTH-2:0], 1'b0};
                    sh_en_s  = 1'b1;
                    busy_s   = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    if (stop_any_s) begin
                        idle_s = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r + 1'b1;
                    busy_s    = 1'b1;
                end
            end
            default: begin
                idle_s = 1'b1;
            end
        endcase

        if (load_s) begin
            // Fresh pattern: MSB goes straight to DIN, the rest waits in shadow.
            state_s   = S_SHIFT;
            cnt_s     = {CW{1'b0}};
            gap_cnt_s = {GW{1'b0}};
            din_s     = bus.pat[WIDTH-1];
            shadow_s  = {bus.pat[WIDTH-2:0], 1'b0};
            sh_en_s   = 1'b1;
            busy_s    = 1'b1;
        end else if (idle_s) begin
            state_s     = S_IDLE;
            gap_cnt_s   = {GW{1'b0}};
            stop_pend_s = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // State, counters and registered outputs; rs clears everything and aborts a frame.
    always_ff @(posedge clk) begin
        if (rs) begin
            state_r     <= S_IDLE;
            shadow_r    <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            gap_cnt_r   <= {GW{1'b0}};
            stop_pend_r <= 1'b0;
            din_r       <= 1'b0;
            sh_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shadow_r    <= shadow_s;
            cnt_r       <= cnt_s;
            gap_cnt_r   <= gap_cnt_s;
            stop_pend_r <= stop_pend_s;
            din_r       <= din_s;
            sh_en_r     <= sh_en_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign bus.DIN   = din_r;
    assign bus.sh_en = sh_en_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_dich_seq.sv
// Bench for dich_seq: two instances (GAP=4 and GAP=0) share the same inputs.
// A timeline model schedules the expected output of every future cycle when a
// frame or gap is launched; a compare process checks both DUTs every cycle.
// Directed scenarios add hand-computed literal checks on top.
module tb_dich_seq;
    logic       clk = 1'b0;
    logic       rs_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] pat_i = 8'h00;
    logic       rpt_i = 1'b0;
    logic       stop_i = 1'b0;

    int tests = 0;
    int fails = 0;

    dich_seq_if #(.WIDTH(8)) if0 ();
    dich_seq_if #(.WIDTH(8)) if1 ();

    assign if0.start = start_i;
    assign if0.pat   = pat_i;
    assign if0.rpt   = rpt_i;
    assign if0.stop  = stop_i;
    assign if1.start = start_i;
    assign if1.pat   = pat_i;
    assign if1.rpt   = rpt_i;
    assign if1.stop  = stop_i;

    dich_seq #(.WIDTH(8), .GAP(4)) dut0 (.clk(clk), .rs(rs_i), .bus(if0));
    dich_seq #(.WIDTH(8), .GAP(0)) dut1 (.clk(clk), .rs(rs_i), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    typedef struct packed {
        logic din;
        logic sh;
        logic busy;
        logic done;
        logic last;
        logic reload;
    } ent_t;

    ent_t tl [2][64];
    logic pend [2];
    int   n = 0;
    bit   armed = 1'b0;

    function automatic int sl(input int x);
        return x % 64;
    endfunction

    task automatic launch(input int d, input int at, input logic [7:0] p);
        for (int i = 0; i < 8; i++) begin
            tl[d][sl(at + i)].din  = p[7 - i];
            tl[d][sl(at + i)].sh   = 1'b1;
            tl[d][sl(at + i)].busy = 1'b1;
            tl[d][sl(at + i)].last = (i == 7);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0;
            for (int k = 0; k < 64; k++) tl[d][k] = '0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   gv;
            ent_t cur;
            logic stopa;
            gv  = (d == 0) ? 4 : 0;
            cur = tl[d][sl(n)];
            tl[d][sl(n)] = '0;
            if (rs_i) begin
                for (int k = 0; k < 64; k++) tl[d][k] = '0;
                pend[d] = 1'b0;
            end else begin
                stopa = pend[d] | stop_i;
                if (cur.last) begin
                    if (rpt_i && !stopa) begin
                        if (gv > 0) begin
                            for (int g = 1; g <= gv; g++) tl[d][sl(n + g)].busy = 1'b1;
                            tl[d][sl(n + gv)].reload = 1'b1;
                        end else begin
                            launch(d, n + 1, pat_i);
                        end
                    end
                    tl[d][sl(n + 1)].done = 1'b1;
                end else if (cur.reload) begin
                    if (!stopa) launch(d, n + 1, pat_i);
                end else if (!cur.busy && start_i) begin
                    launch(d, n + 1, pat_i);
                end
                if (tl[d][sl(n + 1)].busy) pend[d] = pend[d] | (cur.busy & stop_i);
                else pend[d] = 1'b0;
            end
        end
        if (rs_i) armed = 1'b1;
        n = n + 1;
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (armed) begin
            ent_t e0, e1;
            e0 = tl[0][sl(n)];
            e1 = tl[1][sl(n)];
            chk($sformatf("cyc%0d gap4 {din,sh_en,busy,done}", n),
                {28'd0, if0.DIN, if0.sh_en, if0.busy, if0.done},
                {28'd0, e0.din, e0.sh, e0.busy, e0.done});
            chk($sformatf("cyc%0d gap0 {din,sh_en,busy,done}", n),
                {28'd0, if1.DIN, if1.sh_en, if1.busy, if1.done},
                {28'd0, e1.din, e1.sh, e1.busy, e1.done});
        end
    end

    // Downstream shift register driven by the GAP=4 instance.
    logic [7:0] led = 8'h00;
    always @(posedge clk) begin
        if (if0.sh_en) led <= {led[6:0], if0.DIN};
    end

    // ---------------- directed helpers ----------------
    logic [3:0] r0 [0:40];
    logic [3:0] r1 [0:40];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rec(input int c);
        r0[c] = {if0.DIN, if0.sh_en, if0.busy, if0.done};
        r1[c] = {if1.DIN, if1.sh_en, if1.busy, if1.done};
    endtask

    task automatic do_reset();
        rs_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; rpt_i = 1'b0;
        tick();
        rs_i = 1'b0;
    endtask

    task automatic go(input logic [7:0] p, input logic r);
        pat_i = p; rpt_i = r; start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    function automatic logic [7:0] byte_of(input int d, input int from);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], (d == 0) ? r0[from + i][3] : r1[from + i][3]};
        return b;
    endfunction

    function automatic int cnt_bit(input int d, input int bitn, input int a, input int b);
        int s;
        s = 0;
        for (int c = a; c <= b; c++) s += (d == 0) ? int'(r0[c][bitn]) : int'(r1[c][bitn]);
        return s;
    endfunction

    initial begin
        tick();
        do_reset();
        chk("reset outputs", {28'd0, if0.DIN, if0.sh_en, if0.busy, if0.done}, 32'd0);

        // 1: single A5 frame
        go(8'hA5, 1'b0);
        for (int c = 1; c <= 12; c++) begin rec(c); tick(); end
        chk("t1 bits", byte_of(0, 1), 8'hA5);
        chk("t1 sh_en count", cnt_bit(0, 2, 1, 12), 8);
        chk("t1 done/busy cyc9", {28'd0, r0[9]}, 32'b0001);
        chk("t1 done count", cnt_bit(0, 0, 1, 12), 1);
        chk("t1 led", led, 8'hA5);

        // 2: repeat with gap, live pattern update
        do_reset();
        go(8'h01, 1'b1);
        for (int c = 1; c <= 30; c++) begin
            rec(c);
            if (c == 1) pat_i = 8'h80;
            if (c == 10) rpt_i = 1'b0;
            tick();
        end
        chk("t2 frame1", byte_of(0, 1), 8'h01);
        chk("t2 frame2", byte_of(0, 13), 8'h80);
        chk("t2 done c9", r0[9][0], 1'b1);
        chk("t2 done c21", r0[21][0], 1'b1);
        chk("t2 done count", cnt_bit(0, 0, 1, 30), 2);
        chk("t2 gap busy", cnt_bit(0, 1, 9, 12), 4);
        chk("t2 gap sh_en", cnt_bit(0, 2, 9, 12), 0);
        chk("t2 busy c21", r0[21][1], 1'b0);

        // 3: stop on 3rd bit of frame 2
        do_reset();
        go(8'h5A, 1'b1);
        for (int c = 1; c <= 35; c++) begin
            rec(c);
            stop_i = (c == 15);
            tick();
        end
        chk("t3 frame2 bits", byte_of(0, 13), 8'h5A);
        chk("t3 frame2 sh_en", cnt_bit(0, 2, 13, 20), 8);
        chk("t3 done/busy c21", {28'd0, r0[21]}, 32'b0001);
        chk("t3 no frame3", cnt_bit(0, 2, 21, 35), 0);

        // 4: reset mid-frame, then clean frame
        do_reset();
        go(8'hFF, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            rec(c);
            rs_i = (c == 5);
            tick();
        end
        chk("t4 bit5 running", r0[5][2], 1'b1);
        chk("t4 after reset", {28'd0, r0[6]}, 32'd0);
        chk("t4 no done", cnt_bit(0, 0, 6, 12), 0);
        go(8'h3C, 1'b0);
        for (int c = 1; c <= 10; c++) begin rec(c); tick(); end
        chk("t4 3C bits", byte_of(0, 1), 8'h3C);
        chk("t4 3C done", r0[9][0], 1'b1);

        // 5: start ignored while busy, accepted in done cycle
        do_reset();
        go(8'hF0, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            rec(c);
            if (c == 2) begin start_i = 1'b1; pat_i = 8'h00; end
            if (c == 10) start_i = 1'b0;
            tick();
        end
        chk("t5 first frame", byte_of(0, 1), 8'hF0);
        chk("t5 dead cycle", {28'd0, r0[9]}, 32'b0001);
        chk("t5 second sh_en", cnt_bit(0, 2, 10, 17), 8);
        chk("t5 second bits", byte_of(0, 10), 8'h00);
        chk("t5 second done", r0[18][0], 1'b1);

        // 6: GAP=0 back-to-back
        do_reset();
        go(8'hC3, 1'b1);
        for (int c = 1; c <= 30; c++) begin
            rec(c);
            if (c == 20) rpt_i = 1'b0;
            tick();
        end
        chk("t6 sh_en continuous", cnt_bit(1, 2, 1, 24), 24);
        chk("t6 frame3 bits", byte_of(1, 17), 8'hC3);
        chk("t6 done c9/17/25", {29'd0, r1[9][0], r1[17][0], r1[25][0]}, 32'b111);
        chk("t6 done count", cnt_bit(1, 0, 1, 30), 3);
        chk("t6 end", {28'd0, r1[25]}, 32'b0001);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rs_i    = ($urandom_range(0, 63) == 0);
            start_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) rpt_i = ~rpt_i;
            stop_i  = ($urandom_range(0, 15) == 0);
            pat_i   = 8'($urandom);
            tick();
        end
        do_reset();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
